booth_mult_32: RTL
==================

# booth_mult_32

Sequential 32×32 signed multiplier using radix-2 Booth recoding. It produces the low 32 bits of the product plus an overflow flag. Each iteration drives the existing 32-bit carry-select adder with the upper partial product and ±multiplicand, then consumes the adder's sum. The block sits in the ALU/multdiv path, directly upstream and downstream of the 32-bit adder.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported because the adder width is fixed.
- ITER, 32: Booth iterations. Must equal WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request. Operands are sampled on the same edge.
- operand_a  in  32  multiplicand (two's complement)
- operand_b  in  32  multiplier (two's complement)
- result  out  32  low 32 bits of a×b. Held until the next accepted start.
- overflow  out  1  1 when the exact 64-bit product does not fit in signed 32 bits
- result_rdy  out  1  one-cycle pulse when result/overflow become valid
- busy  out  1  high from the accepted start through the DONE cycle

## Operation
- Registers:
  - mcand[31:0] holds the latched operand_a.
  - prod[64:0] = {hi[31:0], lo[31:0], q_m1}.
  - cnt[5:0] counts iterations.
- FSM:
  - IDLE: start=1 loads mcand←operand_a, hi←0, lo←operand_b, q_m1←0, cnt←0, then goes to RUN. Otherwise stays in IDLE.
  - RUN: performs one Booth step per cycle. After the step with cnt=31, goes to DONE.
  - DONE: latches result and overflow, pulses result_rdy, then goes to IDLE.
- Booth step, selected on {lo[0], q_m1}:
  - 00 or 11: no add; hi'=hi.
  - 01: hi' = hi + mcand. Adder inputs (hi, mcand, c_in=0).
  - 10: hi' = hi − mcand. Adder inputs (hi, ~mcand, c_in=1).
  - Then arithmetic-shift {hi', lo, q_m1} right by 1.
- Shift-in bit is the exact sign of the 33-bit sum: s = sum[31] ^ v, where v = (x[31]==y[31]) & (sum[31]!=x[31]) and x, y are the adder operands as driven. This is required so that mcand = 0x80000000 and transient adder overflow shift correctly. For no-add steps, s = hi[31].
- Completion:
  - result = lo after 32 steps.
  - overflow = 1 unless hi bits [31:0] all equal lo[31].
- start is ignored while busy=1. No queueing.
- Outputs change only on an accepted start (result/overflow keep their old values until DONE) or in DONE.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, result_rdy=0, result=0, overflow=0.
  - cnt=0, prod=0, mcand=0.
- Latency:
  - start is sampled at edge E0.
  - busy=1 after E0.
  - 32 RUN steps occur on edges E1..E32.
  - DONE occupies the cycle after E32; result_rdy=1 and new result visible after E33.
  - busy=0 after E34.
  - Next start is accepted at E34 at the earliest. Start-to-ready is 33 cycles.
- start during RUN or DONE: no effect on state, outputs, or latched operands.
- reset asserted in any cycle:
  - Takes priority over start.
  - Returns to IDLE with all reset values on that edge.
  - Any in-flight operation is discarded; no result_rdy pulse.
- The adder path is combinational within one cycle (hi → adder → shift → prod register).

## Structure
- Shared package:
  - FSM state encoding (IDLE, RUN, DONE).
  - ITER_LAST = 31.
  - Booth select codes.
- Sub-module: one instance of the existing 32-bit carry-select adder (CSA_32bits), fed by the operand-select mux.
- Operand-select mux, shift, and overflow check are local logic in booth_mult_32.

## Test plan
- Reset, then start with a=3, b=4 → result_rdy exactly 33 cycles after start, result=0x0000000C, overflow=0, busy low the next cycle.
- a=−7 (0xFFFFFFF9), b=6 → result=0xFFFFFFD6, overflow=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF → result=1, overflow=0.
- a=0x7FFFFFFF, b=2 → result=0xFFFFFFFE, overflow=1. Then a=0x80000000, b=1 → result=0x80000000, overflow=0.
- a=0x80000000, b=0xFFFFFFFF → result=0x80000000, overflow=1. a=0x80000000, b=0x80000000 → result=0, overflow=1.
- start at a=5, b=5. Re-pulse start with a=9, b=9 on cycle 10 → ignored, result=25 at cycle 33. result stays 25 until the next accepted start.
- start at a=100, b=100. Assert reset at cycle 15 → all outputs 0 the next cycle, no result_rdy. A new start with a=2, b=3 afterwards gives result=6 at +33.

Source files
------------

// File: rtl/booth_mult_32_pkg.sv
// rtl/booth_mult_32_pkg.sv - shared state encoding and Booth select codes for booth_mult_32
package booth_mult_32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ITER_LAST = 31;

    // Indexed by {lo[0], q_m1}
    typedef enum logic [1:0] {
        SEL_NOP0 = 2'b00,
        SEL_ADD  = 2'b01,
        SEL_SUB  = 2'b10,
        SEL_NOP1 = 2'b11
    } booth_sel_t;

endpackage

// File: rtl/CSA_32bits.sv
// rtl/CSA_32bits.sv - 32-bit carry-select adder, lower half ripples, upper half pre-computed for both carries
module CSA_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum
);

    logic [16:0] lo_sum;
    logic [15:0] hi_sum0;
    logic [15:0] hi_sum1;

    assign lo_sum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, c_in};
    assign hi_sum0 = a[31:16] + b[31:16];
    assign hi_sum1 = a[31:16] + b[31:16] + 16'd1;
    assign sum     = {(lo_sum[16] ? hi_sum1 : hi_sum0), lo_sum[15:0]};

endmodule

// File: rtl/booth_mult_32.sv
// rtl/booth_mult_32.sv - sequential 32x32 signed radix-2 Booth multiplier, low word plus overflow flag
module booth_mult_32
    import booth_mult_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             result_rdy,
    output logic             busy
);

    if (WIDTH != 32 || ITER != ITER_LAST + 1) begin : g_bad_params
        $error("booth_mult_32 supports only WIDTH = ITER = 32");
    end

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q_m1;
    logic [5:0]       cnt;

    booth_sel_t       sel;
    logic             do_add;
    logic             c_in;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             add_v;
    logic [WIDTH-1:0] hi_step;
    logic             shift_in;

    assign sel    = booth_sel_t'({lo[0], q_m1});
    assign do_add = (sel == SEL_ADD) || (sel == SEL_SUB);
    assign c_in   = (sel == SEL_SUB);
    assign add_b  = c_in ? ~mcand : mcand;

    CSA_32bits u_adder (
        .a    (hi),
        .b    (add_b),
        .c_in (c_in),
        .sum  (sum)
    );

    // The adder can overflow transiently (e.g. mcand = 0x80000000); shift in the true 33-bit sign.
    assign add_v    = (hi[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != hi[WIDTH-1]);
    assign hi_step  = do_add ? sum : hi;
    assign shift_in = do_add ? (sum[WIDTH-1] ^ add_v) : hi[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            mcand      <= '0;
            hi         <= '0;
            lo         <= '0;
            q_m1       <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    result_rdy <= 1'b0;
                    busy       <= start;
                    if (start) begin
                        mcand <= operand_a;
                        hi    <= '0;
                        lo    <= operand_b;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    hi   <= {shift_in, hi_step[WIDTH-1:1]};
                    lo   <= {hi_step[0], lo[WIDTH-1:1]};
                    q_m1 <= lo[0];
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'(ITER_LAST)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result     <= lo;
                    overflow   <= (hi != {WIDTH{lo[WIDTH-1]}});
                    result_rdy <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
